onehot_grant_arbiter: RTL

//  Round-robin arbiter driving N mutually exclusive grant lines. It is the producer side of the

---
 rtl/onehot_grant_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/onehot_grant_arbiter.sv
// Purpose     : round-robin arbiter issuing one multi-beat tenure at a time on onehot0 grant lines.
// Latency     : req -> gnt 1 cycle; release and handoff to the next requester on the same edge.
// Backpressure: quiesce blocks new tenures only; an active tenure always runs to completion.
//
// Ports:
//   clock     - single clock, all state updates on posedge
//   reset_n   - asynchronous active-low reset
//   quiesce   - 1 = start no new tenure
//   req       - per-requester level request, held for the whole tenure
//   req_last  - last beat of tenure, only meaningful for the current holder
//   gnt       - registered onehot0 grant
//   gnt_valid - registered |gnt
//   gnt_id    - index of the set gnt bit, 0 when idle
//   abort     - 1-cycle pulse: holder dropped req without req_last
//   timeout   - 1-cycle pulse: tenure forcibly ended after MAX_HOLD cycles
module onehot_grant_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 quiesce,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 abort,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0]  ONE     = N'(1);
    localparam logic [CW-1:0] HOLD_MX = CW'(MAX_HOLD);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_ptr;
    logic [CW-1:0]  r_hold_cnt;
    logic [N-1:0]   r_gnt;
    logic           r_gnt_valid;
    logic [IW-1:0]  r_gnt_id;
    logic           r_abort;
    logic           r_timeout;

    state_t         w_state_n;
    logic [IW-1:0]  w_ptr_n;
    logic [CW-1:0]  w_cnt_n;
    logic [N-1:0]   w_gnt_n;
    logic [IW-1:0]  w_id_n;
    logic           w_abort_n;
    logic           w_timeout_n;
    logic           w_rel;
    logic [IW:0]    w_pick;

    // Index increment modulo N (N need not be a power of two).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(N - 1)) ? '0 : v + 1'b1;
    endfunction

    // Round-robin scan starting at base; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] base);
        logic [IW-1:0] idx;
        logic [IW-1:0] sel;
        logic          found;
        idx   = base;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && r[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = wrap_inc(idx);
        end
        return {found, sel};
    endfunction

    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_cnt_n     = r_hold_cnt;
        w_gnt_n     = r_gnt;
        w_id_n      = r_gnt_id;
        w_abort_n   = 1'b0;
        w_timeout_n = 1'b0;
        w_rel       = 1'b0;
        w_pick      = '0;

        case (r_state)
            ST_IDLE: begin
                w_pick = rr_pick(req, r_ptr);
                if (!quiesce && w_pick[IW]) begin
                    w_state_n = ST_BUSY;
                    w_gnt_n   = ONE << w_pick[IW-1:0];
                    w_id_n    = w_pick[IW-1:0];
                    w_cnt_n   = CW'(1);
                end
            end

            ST_BUSY: begin
                // Release causes in priority order: abort, last beat, timeout.
                if (!req[r_gnt_id]) begin
                    w_rel     = 1'b1;
                    w_abort_n = 1'b1;
                end else if (req_last[r_gnt_id]) begin
                    w_rel = 1'b1;
                end else if (r_hold_cnt == HOLD_MX) begin
                    w_rel       = 1'b1;
                    w_timeout_n = 1'b1;
                end

                if (w_rel) begin
                    // Handoff on the release edge; the outgoing holder is masked so a
                    // lone continuous requester sees exactly one idle cycle.
                    w_ptr_n = wrap_inc(r_gnt_id);
                    w_pick  = rr_pick(req & ~r_gnt, w_ptr_n);
                    if (!quiesce && w_pick[IW]) begin
                        w_gnt_n = ONE << w_pick[IW-1:0];
                        w_id_n  = w_pick[IW-1:0];
                        w_cnt_n = CW'(1);
                    end else begin
                        w_state_n = ST_IDLE;
                        w_gnt_n   = '0;
                        w_id_n    = '0;
                        w_cnt_n   = '0;
                    end
                end else if (r_hold_cnt != HOLD_MX) begin
                    w_cnt_n = r_hold_cnt + 1'b1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_gnt_n   = '0;
                w_id_n    = '0;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_abort     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_hold_cnt  <= w_cnt_n;
            r_gnt       <= w_gnt_n;
            r_gnt_valid <= |w_gnt_n;
            r_gnt_id    <= w_id_n;
            r_abort     <= w_abort_n;
            r_timeout   <= w_timeout_n;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign abort     = r_abort;
    assign timeout   = r_timeout;

endmodule
